// File: rtl/muxbus_target.sv
// Target for the multiplexed address/data bus: address latch, word RAM, console TX FIFO with
// status window, and a read-ready handshake with configurable wait states.
module muxbus_target #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DEPTH       = 4096,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned CON_ADDR    = 'hFE00,
    parameter int unsigned STAT_LO     = 'hFE02,
    parameter int unsigned STAT_HI     = 'hFE12,
    parameter int unsigned STAT_CONST  = 'h0188,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic              wb_clk_i,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] bus_i,
    input  logic              latch_en_i,
    input  logic              bus_dir_i,
    input  logic              oe_n_i,
    input  logic              we_n_i,
    output logic [DATA_W-1:0] bus_o,
    output logic              bus_oe,
    output logic              rdy_o,
    output logic [7:0]        con_data_o,
    output logic              con_valid_o,
    input  logic              con_ready_i,
    output logic              con_ovf_o,
    output logic              err_o
);

    localparam int unsigned RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FIFO_PW = $clog2(FIFO_DEPTH);
    localparam int unsigned FIFO_CW = FIFO_PW + 1;
    localparam logic [FIFO_PW:0] FIFO_FULL_CNT = FIFO_CW'(FIFO_DEPTH);
    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {StIdle, StWait, StData} rd_state_e;

    rd_state_e         state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] bus_q, bus_d;
    logic              rdy_q, rdy_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              latch_en_q, oe_n_q, we_n_q;
    logic              ovf_q, ovf_d;
    logic              err_q, err_d;

    logic [FIFO_PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_PW:0]   fifo_cnt_q, fifo_cnt_d;
    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [DATA_W-1:0]  ram [DEPTH];

    logic [ADDR_W-1:0] full_addr;
    logic [31:0]       addr_ext, word_idx;
    logic [RAM_AW-1:0] ram_idx;
    logic              is_con, is_stat, in_ram;
    logic              oe_fall, we_rise, conflict;
    logic              fifo_full, fifo_pop, fifo_push, push_req, ram_we;
    logic [DATA_W-1:0] stat_word, rdata;

    assign full_addr = latch_en_i ? bus_i[ADDR_W-1:0] : addr_q;
    assign addr_ext  = 32'(full_addr);
    assign word_idx  = addr_ext >> 1;
    assign ram_idx   = word_idx[RAM_AW-1:0];
    assign is_con    = (addr_ext == CON_ADDR);
    assign is_stat   = (addr_ext >= STAT_LO) && (addr_ext <= STAT_HI);
    assign in_ram    = (word_idx < DEPTH);

    assign oe_fall  = oe_n_q & ~oe_n_i;
    // Gated by rst_n so a strobe edge coinciding with reset never reaches RAM or FIFO.
    assign we_rise  = rst_n & ~we_n_q & we_n_i;
    assign conflict = ~oe_n_i & ~we_n_i;

    assign con_valid_o = (fifo_cnt_q != '0);
    assign fifo_full   = (fifo_cnt_q == FIFO_FULL_CNT);
    assign fifo_pop    = con_valid_o & con_ready_i;
    assign push_req    = we_rise & is_con;
    assign fifo_push   = push_req & (~fifo_full | fifo_pop);
    assign ram_we      = we_rise & ~is_con & ~is_stat & in_ram;

    always_comb begin
        stat_word = DATA_W'(STAT_CONST);
        stat_word[0] = stat_word[0] | ~con_valid_o;
        stat_word[1] = stat_word[1] | fifo_full;
        stat_word[DATA_W-1] = stat_word[DATA_W-1] | ovf_q;
        if (is_stat) begin
            rdata = stat_word;
        end else if (is_con || !in_ram) begin
            rdata = '0;
        end else begin
            rdata = ram[ram_idx];
        end
    end

    // Read FSM; a strobe conflict always drops back to idle because the write wins.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        rdy_d      = rdy_q;
        bus_d      = bus_q;
        if (conflict) begin
            state_d = StIdle;
            rdy_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (oe_fall) begin
                        state_d    = StWait;
                        wait_cnt_d = '0;
                    end
                end
                StWait: begin
                    if (oe_n_i) begin
                        state_d = StIdle;
                    end else if (wait_cnt_q == WAIT_CNT) begin
                        state_d = StData;
                        rdy_d   = 1'b1;
                        bus_d   = rdata;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                end
                StData: begin
                    if (oe_n_i) begin
                        state_d = StIdle;
                        rdy_d   = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        addr_d   = (latch_en_q && !latch_en_i) ? bus_i[ADDR_W-1:0] : addr_q;
        wr_ptr_d = wr_ptr_q + FIFO_PW'(fifo_push);
        rd_ptr_d = rd_ptr_q + FIFO_PW'(fifo_pop);
        case ({fifo_push, fifo_pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        ovf_d = ovf_q | (push_req & fifo_full & ~fifo_pop);
        err_d = err_q | conflict;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            bus_q      <= '0;
            rdy_q      <= 1'b0;
            addr_q     <= '0;
            latch_en_q <= 1'b0;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            bus_q      <= bus_d;
            rdy_q      <= rdy_d;
            addr_q     <= addr_d;
            latch_en_q <= latch_en_i;
            oe_n_q     <= oe_n_i;
            we_n_q     <= we_n_i;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (ram_we) begin
            ram[ram_idx] <= bus_i;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr_q] <= bus_i[7:0];
        end
    end

    assign bus_o      = bus_q;
    assign bus_oe     = bus_dir_i & ~oe_n_i;
    assign rdy_o      = rdy_q;
    assign con_data_o = con_valid_o ? fifo_mem[rd_ptr_q] : 8'h00;
    assign con_ovf_o  = ovf_q;
    assign err_o      = err_q;

endmodule

// File: doc/muxbus_target.md
Name: muxbus_target

Overview:
- Synthesizable, parametrised target for the multiplexed address/data external bus used by the CPU wrappers: transparent address latch, word RAM, console TX port with status register, wait-state ready handshake.
- Replaces bench-only memory models; used for FPGA emulation and as the standard bench responder for every bus-mastering core in the multiplexer.
- All bus inputs are already synchronous to wb_clk_i. The block detects bus strobes by edge detection on registered copies.

Parameters:
DATA_W, 16, bus/data width in bits (even, >=8)
ADDR_W, 16, byte-address width
DEPTH, 4096, RAM depth in words; word index = addr >> 1
WAIT_STATES, 0, extra clocks between read strobe and data valid (0..15)
CON_ADDR, 'hFE00, console TX data address (write low byte)
STAT_LO, 'hFE02, first status address (inclusive)
STAT_HI, 'hFE12, last status address (inclusive)
STAT_CONST, 'h0188, constant OR'd into status read data
FIFO_DEPTH, 8, console FIFO entries (power of two, >=2)

Ports:
wb_clk_i  in  1  clock
rst_n  in  1  synchronous active-low reset
bus_i  in  DATA_W  bus from master (address during latch phase, write data otherwise)
latch_en_i  in  1  address latch enable (transparent while high)
bus_dir_i  in  1  1 = master expects target to drive bus
oe_n_i  in  1  read strobe, active low
we_n_i  in  1  write strobe, active low; write commits on rising edge
bus_o  out  DATA_W  read data
bus_oe  out  1  target drives bus_o
rdy_o  out  1  read data valid
con_data_o  out  8  console FIFO head
con_valid_o  out  1  FIFO not empty
con_ready_i  in  1  sink accepts head
con_ovf_o  out  1  sticky: console byte dropped on full FIFO
err_o  out  1  sticky: oe_n and we_n both low in the same cycle

Behaviour:
- Reset (rst_n=0 at a clk edge): addr_q=0, bus_o=0, bus_oe=0, rdy_o=0, FIFO empty (con_valid_o=0, con_data_o=0), con_ovf_o=0, err_o=0, read FSM IDLE. RAM is not cleared. Reset during a read or write aborts it with no RAM or FIFO update.
- Address: full_addr = latch_en_i ? bus_i[ADDR_W-1:0] : addr_q. addr_q loads bus_i on the cycle latch_en_i is seen falling (reg=1, now=0).
- bus_oe = bus_dir_i & ~oe_n_i, combinational.
- Read FSM:
  - IDLE -> WAIT when oe_n falls. Count WAIT_STATES cycles.
  - WAIT -> DATA: bus_o loads read data and rdy_o=1 on the next clock. Latency is 1+WAIT_STATES clocks after the falling-edge cycle.
  - DATA holds bus_o and rdy_o until oe_n_i=1. Then rdy_o=0 next cycle, bus_o holds its value, return to IDLE.
  - oe_n rising before DATA: return to IDLE, rdy_o stays 0.
- Read data:
  - STAT_LO<=addr<=STAT_HI: STAT_CONST | {fifo_full at bit 1, ~con_valid_o at bit 0} | {con_ovf_o at bit 15}.
  - CON_ADDR: 0.
  - Word index >= DEPTH: 0.
  - Otherwise RAM[addr>>1].
- Write: on the cycle we_n rises (reg=0, now=1), bus_i is captured at full_addr.
  - CON_ADDR: push bus_i[7:0] to FIFO. If FIFO full and no pop in the same cycle, drop the byte and set con_ovf_o. RAM is not written.
  - Status range: ignored.
  - Word index >= DEPTH: ignored.
  - Otherwise RAM[addr>>1] <= bus_i.
- Full-word writes only; bit 0 of the address is ignored for RAM.
- FIFO:
  - Pop when con_valid_o & con_ready_i. con_data_o always shows the head.
  - Push and pop in the same cycle when full: both succeed, count unchanged.
  - Push and pop in the same cycle when empty: push only.
  - Pointers wrap modulo FIFO_DEPTH.
- Conflict: oe_n_i=0 & we_n_i=0 in any cycle sets err_o. The write still commits on the we_n rise. Writes take priority; the read FSM returns to IDLE with rdy_o=0.
- Sticky flags clear only on reset.

Test Plan:
- Latch 'h0100 (latch_en high->low), write 'hBEEF via we_n pulse, then read 'h0100 with WAIT_STATES=0 -> bus_o='hBEEF, rdy_o=1 exactly 1 clock after the oe_n fall cycle; bus_oe=1 only while bus_dir_i=1 & oe_n_i=0.
- WAIT_STATES=3: read a preloaded word -> rdy_o rises 4 clocks after the oe_n fall. Release oe_n after 2 clocks -> rdy_o never asserts, FSM back in IDLE.
- Write 'h48,'h69 to 'hFE00 with con_ready_i=0 -> con_valid_o=1, con_data_o='h48. Read 'hFE04 -> 'h0188. Raise con_ready_i -> 'h48 then 'h69 pop, con_valid_o=0. Read 'hFE04 again -> 'h0189.
- FIFO_DEPTH=8: push 9 bytes with con_ready_i=0 -> 9th dropped, con_ovf_o=1, status bit1=1, bit15=1. Push while popping when full -> accepted, con_ovf_o unchanged.
- Address 'hFFFE (index >= DEPTH): write 'h1234 then read -> 'h0000, RAM unchanged. Drive oe_n=we_n=0 together -> err_o=1, write commits.
- Assert rst_n=0 mid-WAIT and with FIFO holding 3 bytes -> next cycle rdy_o=0, con_valid_o=0, flags cleared; RAM still returns prior 'hBEEF at 'h0100.
